// File: rtl/clapton_sweep_ctrl_pkg.sv
// Shared types, sizing constants and the reference datapath function for the
// clapton sweep controller.
package clapton_sweep_ctrl_pkg;

    localparam int NSEL        = 16;
    localparam int LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Y of the A/B/C-select datapath for one B code, used to predict a sweep.
    function automatic logic ref_y(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic y;
        case (b[1:0])
            2'b00:   y = 1'b1;
            2'b01:   y = 1'b0;
            2'b10:   y = c[b[3:2]];
            default: y = a[3];
        endcase
        return y;
    endfunction

endpackage

// File: rtl/clapton_sweep_ctrl_lat_pipe.sv
// LAT-deep shift register of issue tokens; its tail strobes the capture of
// the datapath output that matches an issued B code.
module clapton_lat_pipe
    import clapton_sweep_ctrl_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic issue,
    output logic strobe
);

    logic [LAT-1:0] pipe_q;
    logic [LAT-1:0] pipe_d;

    // Next token vector: shift in the issue flag, or empty on flush.
    always_comb begin
        pipe_d = {LAT{1'b0}};
        if (flush) begin
            pipe_d = {LAT{1'b0}};
        end else begin
            pipe_d[0] = issue;
            for (int k = 1; k < LAT; k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
        end
    end

    // Token register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_q <= {LAT{1'b0}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign strobe = pipe_q[LAT-1];

endmodule

// File: rtl/clapton_sweep_ctrl.sv
// Sweep sequencer: accepts {A, C}, walks B through all 16 codes on the
// datapath, gathers the latency-aligned Y bits and returns them as one word.
module clapton_sweep_ctrl
    import clapton_sweep_ctrl_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_a,
    input  logic [3:0]      cmd_c,
    input  logic            abort,
    output logic [3:0]      dp_a,
    output logic [3:0]      dp_b,
    output logic [3:0]      dp_c,
    input  logic            dp_y,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [NSEL-1:0] res_word,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [3:0]      dp_a_q, dp_a_d;
    logic [3:0]      dp_b_q, dp_b_d;
    logic [3:0]      dp_c_q, dp_c_d;
    logic [3:0]      cap_q, cap_d;
    logic [NSEL-1:0] res_word_q, res_word_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q, busy_d;
    logic            issue_s;
    logic            flush_s;
    logic            cap_stb_s;

    // dp_b doubles as the issue counter: a token enters the pipe every SWEEP cycle.
    assign issue_s = (state_q == ST_SWEEP);

    clapton_lat_pipe #(
        .LAT(LAT)
    ) u_lat_pipe (
        .clk   (clk),
        .reset (reset),
        .flush (flush_s),
        .issue (issue_s),
        .strobe(cap_stb_s)
    );

    // Next-state, issue, capture and abort decisions.
    always_comb begin
        state_d    = state_q;
        dp_a_d     = dp_a_q;
        dp_b_d     = dp_b_q;
        dp_c_d     = dp_c_q;
        cap_d      = cap_q;
        res_word_d = res_word_q;
        flush_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    dp_a_d     = cmd_a;
                    dp_c_d     = cmd_c;
                    dp_b_d     = 4'd0;
                    cap_d      = 4'd0;
                    res_word_d = {NSEL{1'b0}};
                    state_d    = ST_SWEEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP, ST_DRAIN: begin
                if (abort) begin
                    // Abort outranks any capture on this edge, including bit 15.
                    state_d    = ST_IDLE;
                    dp_b_d     = 4'd0;
                    cap_d      = 4'd0;
                    res_word_d = {NSEL{1'b0}};
                    flush_s    = 1'b1;
                end else begin
                    if (cap_stb_s) begin
                        res_word_d[cap_q] = dp_y;
                        cap_d             = cap_q + 4'd1;
                    end else begin
                        cap_d = cap_q;
                    end
                    if (state_q == ST_SWEEP) begin
                        if (dp_b_q == 4'd15) begin
                            state_d = ST_DRAIN;
                        end else begin
                            dp_b_d = dp_b_q + 4'd1;
                        end
                    end else begin
                        if (cap_stb_s && (cap_q == 4'd15)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_SWEEP) || (state_d == ST_DRAIN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dp_a_q      <= 4'd0;
            dp_b_q      <= 4'd0;
            dp_c_q      <= 4'd0;
            cap_q       <= 4'd0;
            res_word_q  <= {NSEL{1'b0}};
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            dp_c_q      <= dp_c_d;
            cap_q       <= cap_d;
            res_word_q  <= res_word_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_c      = dp_c_q;
    assign res_valid = res_valid_q;
    assign res_word  = res_word_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_clapton_sweep_ctrl.sv
// Bench for clapton_sweep_ctrl: a LAT=2 and a LAT=3 instance, each driving a
// behavioural datapath, checked every cycle against a timeline model.
module tb_clapton_sweep_ctrl;
    import clapton_sweep_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       cmd_valid, cmd_ready, abort, dp_y, res_valid, res_ready, busy;
    logic [1:0][3:0]  cmd_a, cmd_c, dp_a, dp_b, dp_c;
    logic [1:0][15:0] res_word;
    int               checks   = 0;
    int               failures = 0;
    bit               tie_ready = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL inst%0d %s: got 0x%0h, want 0x%0h at %0t", k, nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sweep_word(input logic [3:0] a, input logic [3:0] c);
        logic [15:0] w = 16'h0000;
        for (int i = 0; i < 16; i++) w[i] = ref_y(a, 4'(i), c);
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 2 : 3;
        logic [3:0]  hist;
        int          m_mode;  // 0 idle, 1 sweeping, 2 result held
        int          m_t;     // cycles since s
        logic        e_crdy, e_rv, e_busy;
        logic [3:0]  e_a, e_b, e_c;
        logic [15:0] e_word, m_full;

        clapton_sweep_ctrl #(.LAT(L)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .cmd_valid(cmd_valid[g]),
            .cmd_ready(cmd_ready[g]),
            .cmd_a    (cmd_a[g]),
            .cmd_c    (cmd_c[g]),
            .abort    (abort[g]),
            .dp_a     (dp_a[g]),
            .dp_b     (dp_b[g]),
            .dp_c     (dp_c[g]),
            .dp_y     (dp_y[g]),
            .res_valid(res_valid[g]),
            .res_ready(res_ready[g]),
            .res_word (res_word[g]),
            .busy     (busy[g])
        );

        // Behavioural datapath: Y for the presented code appears L cycles later.
        always @(posedge clk) hist <= {hist[2:0], ref_y(dp_a[g], dp_b[g], dp_c[g])};
        assign dp_y[g] = hist[L-1];

        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                m_mode <= 0; m_t <= 0; e_crdy <= 1'b0; e_rv <= 1'b0; e_busy <= 1'b0;
                e_a <= 4'd0; e_b <= 4'd0; e_c <= 4'd0; e_word <= 16'h0000; m_full <= 16'h0000;
            end else if (m_mode == 0) begin
                if (cmd_valid[g] && e_crdy) begin
                    m_mode <= 1; m_t <= 0; e_crdy <= 1'b0; e_busy <= 1'b1;
                    e_a <= cmd_a[g]; e_c <= cmd_c[g]; e_b <= 4'd0; e_word <= 16'h0000;
                    m_full <= sweep_word(cmd_a[g], cmd_c[g]);
                end else begin
                    e_crdy <= 1'b1;
                end
            end else if (m_mode == 1) begin
                if (abort[g]) begin
                    m_mode <= 0; e_b <= 4'd0; e_word <= 16'h0000; e_busy <= 1'b0; e_crdy <= 1'b1;
                end else if (m_t == 15 + L) begin
                    m_mode <= 2; e_rv <= 1'b1; e_busy <= 1'b0; e_word <= m_full;
                end else begin
                    m_t <= m_t + 1;
                    e_b <= (m_t + 1 > 15) ? 4'd15 : 4'(m_t + 1);
                end
            end else begin
                if (res_ready[g]) begin
                    m_mode <= 0; e_rv <= 1'b0; e_crdy <= 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            check(g, "cmd_ready", 32'(cmd_ready[g]), 32'(e_crdy));
            check(g, "busy", 32'(busy[g]), 32'(e_busy));
            check(g, "res_valid", 32'(res_valid[g]), 32'(e_rv));
            check(g, "dp_a", 32'(dp_a[g]), 32'(e_a));
            check(g, "dp_b", 32'(dp_b[g]), 32'(e_b));
            check(g, "dp_c", 32'(dp_c[g]), 32'(e_c));
            if (!e_busy) check(g, "res_word", 32'(res_word[g]), 32'(e_word));
        end
    end

    task automatic start_cmd(input int k, input logic [3:0] a, input logic [3:0] c);
        int i = 0;
        @(negedge clk);
        cmd_a[k] = a; cmd_c[k] = c; cmd_valid[k] = 1'b1;
        while (cmd_ready[k] !== 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check(k, "accept_in_time", 32'(i < 100), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid[k] = 1'b0;
    endtask

    task automatic wait_result(input int k, input int exp_lat, input logic [15:0] exp_word);
        int n = 0;
        while (res_valid[k] !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check(k, "res_latency", 32'(n), 32'(exp_lat));
        check(k, "res_word_lit", 32'(res_word[k]), 32'(exp_word));
    endtask

    task automatic take_result(input int k);
        res_ready[k] = 1'b1;
        @(negedge clk);
        res_ready[k] = tie_ready;
        check(k, "ready_after_take", 32'(cmd_ready[k]), 32'd1);
        check(k, "valid_after_take", 32'(res_valid[k]), 32'd0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 2'b00; abort = 2'b00; res_ready = 2'b00;
        cmd_a = 8'h00; cmd_c = 8'h00;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check(0, "rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        check(0, "rst_dp_b", 32'(dp_b[0]), 32'd0);
        check(0, "rst_res_valid", 32'(res_valid[0]), 32'd0);
        check(0, "rst_res_word", 32'(res_word[0]), 32'd0);
        check(0, "rst_busy", 32'(busy[0]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check(0, "ready_after_release", 32'(cmd_ready[0]), 32'd1);

        // Basic sweep, LAT=2.
        start_cmd(0, 4'b1010, 4'b0110);
        check(0, "s_dp_b", 32'(dp_b[0]), 32'd0);
        check(0, "s_busy", 32'(busy[0]), 32'd1);
        wait_result(0, 18, 16'h9DD9);
        take_result(0);

        // Back-to-back with res_ready tied high.
        tie_ready = 1'b1; res_ready[0] = 1'b1;
        start_cmd(0, 4'b0000, 4'b0000);
        wait_result(0, 18, 16'h1111);
        take_result(0);
        start_cmd(0, 4'b1000, 4'b1111);
        wait_result(0, 18, 16'hDDDD);
        take_result(0);
        tie_ready = 1'b0; res_ready[0] = 1'b0;

        // Result held for 10 cycles while a new command waits.
        start_cmd(0, 4'b1010, 4'b0110);
        wait_result(0, 18, 16'h9DD9);
        cmd_a[0] = 4'b0000; cmd_c[0] = 4'b0000; cmd_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check(0, "hold_valid", 32'(res_valid[0]), 32'd1);
            check(0, "hold_word", 32'(res_word[0]), 32'h9DD9);
            check(0, "hold_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        end
        res_ready[0] = 1'b1;
        @(negedge clk);
        res_ready[0] = 1'b0;
        check(0, "take_no_accept", 32'(busy[0]), 32'd0);
        check(0, "take_ready", 32'(cmd_ready[0]), 32'd1);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check(0, "late_accept_busy", 32'(busy[0]), 32'd1);
        check(0, "late_accept_dp_b", 32'(dp_b[0]), 32'd0);
        wait_result(0, 18, 16'h1111);
        take_result(0);

        // Abort mid-sweep, then abort on the bit-15 capture edge.
        start_cmd(0, 4'b1010, 4'b0110);
        repeat (7) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check(0, "abort7_busy", 32'(busy[0]), 32'd0);
        check(0, "abort7_ready", 32'(cmd_ready[0]), 32'd1);
        check(0, "abort7_dp_b", 32'(dp_b[0]), 32'd0);
        check(0, "abort7_word", 32'(res_word[0]), 32'd0);
        start_cmd(0, 4'b1010, 4'b0110);
        repeat (17) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check(0, "abort15_busy", 32'(busy[0]), 32'd0);
        check(0, "abort15_word", 32'(res_word[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check(0, "abort15_no_valid", 32'(res_valid[0]), 32'd0);
            @(negedge clk);
        end
        start_cmd(0, 4'b1010, 4'b0110);
        wait_result(0, 18, 16'h9DD9);
        take_result(0);

        // Asynchronous reset in DRAIN.
        start_cmd(0, 4'b1010, 4'b0110);
        repeat (16) @(negedge clk);
        check(0, "drain_busy", 32'(busy[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check(0, "arst_dp_a", 32'(dp_a[0]), 32'd0);
        check(0, "arst_dp_b", 32'(dp_b[0]), 32'd0);
        check(0, "arst_dp_c", 32'(dp_c[0]), 32'd0);
        check(0, "arst_busy", 32'(busy[0]), 32'd0);
        check(0, "arst_valid", 32'(res_valid[0]), 32'd0);
        check(0, "arst_word", 32'(res_word[0]), 32'd0);
        check(0, "arst_ready", 32'(cmd_ready[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check(0, "release_ready0", 32'(cmd_ready[0]), 32'd0);
        @(negedge clk);
        check(0, "release_ready1", 32'(cmd_ready[0]), 32'd1);

        // LAT=3 instance.
        start_cmd(1, 4'b1010, 4'b0110);
        wait_result(1, 19, 16'h9DD9);
        take_result(1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
